ntt_pass_sequencer: RTL and testbench
=====================================

# ntt_pass_sequencer

Parametrised multi-pass NTT/INTT sequencer for E-lane butterfly datapaths; successor to the single-pass NTT controller. One start runs a full transform of 2^(LOG_N−diff_log_n) coefficients as a series of passes of up to LOG_E levels each. Each pass issues bit-reversed E-wide chunk reads to the buffer RAM and tracks a fixed-latency butterfly pipeline with a valid shift register. It writes results back in place and supplies per-pass level/skip configuration to the datapath. Sits between the FHE ALU command decoder and the butterfly array/buffer RAM.

## Interface
- LOG_N, 16, log2 of max ring dimension
- LOG_E, 3, log2 of lanes per chunk; ADDR_W = LOG_N−LOG_E
- PIPE_LAT, 40, cycles from rd_en to the matching wr_en (≥2)
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- start  in  1  launch pulse; sampled only in IDLE
- inverse  in  1  0 = NTT (ascending passes), 1 = INTT (descending passes); latched at start
- diff_log_n  in  $clog2(ADDR_W+1)  ring-size reduction; latched at start
- stall  in  1  suppresses new reads; in-flight data keeps moving
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at completion
- cfg_err  out  1  one-cycle pulse when start is rejected
- rd_en  out  1  chunk read strobe
- rd_addr  out  ADDR_W  chunk read address
- wr_en  out  1  chunk write strobe
- wr_addr  out  ADDR_W  chunk write address
- pass_idx  out  $clog2(LOG_N)  current pass number
- pass_base_level  out  $clog2(LOG_N)  first NTT level of the pass
- pass_levels  out  $clog2(LOG_E+1)  active levels in the pass (1..LOG_E)
- skip_mask  out  LOG_E  bit g set ⇔ stage g < LOG_E−pass_levels (bypass)

## Operation
- Derived at start:
  - CHUNKS = 2^(ADDR_W−d).
  - L = LOG_N−d.
  - P = ceil(L/LOG_E).
  - Pass k (execution order) covers logical pass j = k for NTT and j = P−1−k for INTT.
  - base = j·LOG_E; levels = min(LOG_E, L−j·LOG_E).
- cfg_err: start in IDLE with diff_log_n > ADDR_W pulses cfg_err next cycle; the block stays IDLE and busy stays low.
- Start while busy is ignored; no error is raised.
- States: IDLE → RUN (on accepted start) → DRAIN (after the last read of the pass) → TURN (last write of the pass done and passes remain) → RUN; DRAIN → DONE (last pass) → IDLE.
- RUN:
  - Each cycle with stall=0: rd_en=1, rd_addr = bitrev_ADDR_W(load_idx) >> d, load_idx++.
  - The read with load_idx = CHUNKS−1 moves the state to DRAIN.
- Valid tracking:
  - rd_en enters a PIPE_LAT-deep shift register; its output drives wr_en.
  - wr_addr = bitrev_ADDR_W(store_idx) >> d, where store_idx counts writes in the pass (0..CHUNKS−1).
- The next pass never reads before every write of the current pass has issued (read-after-write safety).
- pass_* and skip_mask are registered:
  - They update on entry to RUN from IDLE and on entry to TURN.
  - They hold stable through RUN and DRAIN.
- done pulses for one cycle in DONE, and busy falls in the same cycle.
- Reset values, and the values in IDLE: busy, done, cfg_err, rd_en, wr_en, all addresses, pass_* and skip_mask are 0.
- Reset mid-operation: all state, counters and the valid shift register clear asynchronously. No wr_en asserts after rstn rises until a new start is accepted.

## Timing
- start sampled at cycle 0 → busy=1 and first rd_en at cycle 1 (unless stall).
- rd_en at cycle t → wr_en at cycle t+PIPE_LAT, exactly, independent of stall.
- Last wr_en of a non-final pass at cycle c → TURN at c+1 (new pass_* visible) → first read of the next pass at c+2.
- Last wr_en of the final pass at cycle c → done=1 and busy=0 at c+1.
- stall: rd_en=0 in that cycle and load_idx holds. Stall has no effect in DRAIN, TURN or IDLE.
- Simultaneous rd_en and wr_en are normal. Both addresses are valid in the same cycle.

## Test plan
- LOG_N=6, LOG_E=3, PIPE_LAT=5, NTT, d=0, start at cycle 0:
  - rd_addr 0,4,2,6,1,5,3,7 at cycles 1–8; wr_en cycles 6–13 with the same address order.
  - TURN at 14 with pass_base_level=3.
  - Pass-1 reads at 15–22, writes at 20–27; done at 28.
- LOG_N=7, LOG_E=3, NTT, d=0:
  - Three passes with (base, levels, skip_mask) = (0,3,000), (3,3,000), (6,1,011).
  - 16 reads and 16 writes per pass.
- Same configuration with inverse=1:
  - Pass order (6,1,011), (3,3,000), (0,3,000); done after 48 writes.
- LOG_N=6, d=3: CHUNKS=1, single pass with base 0 and levels 3. d=4: cfg_err pulse, busy stays 0.
- stall high at cycles 3–5 in the first configuration:
  - Reads resume at cycle 6 with the next address; 8 reads total.
  - Each wr_en lands exactly PIPE_LAT after its read; done is delayed by 3 cycles.
- rstn low at cycle 10 of the first configuration:
  - All outputs are 0 immediately; no wr_en afterwards.
  - A new start then runs the full sequence correctly. A start pulse during busy is ignored.

Source files
------------

// File: rtl/ntt_pass_sequencer.sv
// Multi-pass NTT/INTT sequencer: bit-reversed chunk reads, fixed-latency
// butterfly tracking, in-place writeback and per-pass level configuration.
module ntt_pass_sequencer #(
    parameter int LOG_N    = 16,
    parameter int LOG_E    = 3,
    parameter int PIPE_LAT = 40,
    localparam int ADDR_W  = LOG_N - LOG_E,
    localparam int DW      = $clog2(ADDR_W + 1),
    localparam int PW      = $clog2(LOG_N),
    localparam int EW      = $clog2(LOG_E + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              inverse,
    input  logic [DW-1:0]     diff_log_n,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PW-1:0]     pass_idx,
    output logic [PW-1:0]     pass_base_level,
    output logic [EW-1:0]     pass_levels,
    output logic [LOG_E-1:0]  skip_mask
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_TURN,
        S_DONE
    } state_t;

    localparam logic [DW-1:0] ADDR_MAX = DW'(ADDR_W);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   load_idx;
    logic [ADDR_W-1:0]   store_idx;
    logic [ADDR_W-1:0]   chunks_m1;
    logic [PIPE_LAT-1:0] vsr;
    logic                inv_q;
    logic [DW-1:0]       d_q;
    logic [PW-1:0]       last_q;
    logic                start_ok;
    logic                start_bad;
    logic                last_rd;
    logic                last_wr;

    logic                inv_s;
    logic [DW-1:0]       d_s;
    int                  k_n;
    int                  l_n;
    int                  p_n;
    int                  j_n;
    int                  base_n;
    int                  lv_n;
    logic [PW-1:0]       last_n;
    logic [PW-1:0]       base_c;
    logic [EW-1:0]       lv_c;
    logic [LOG_E-1:0]    mask_c;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = v[ADDR_W-1-i];
        end
        return r;
    endfunction

    assign chunks_m1 = {ADDR_W{1'b1}} >> d_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN) ||
                       (state_q == S_TURN);
    assign done      = (state_q == S_DONE);
    assign rd_addr   = rd_en ? (bitrev(load_idx) >> d_q) : '0;
    assign wr_addr   = wr_en ? (bitrev(store_idx) >> d_q) : '0;

    // Config for the pass about to start: first pass from live inputs,
    // later passes from the latched settings and pass_idx+1.
    always_comb begin
        inv_s  = (state_q == S_IDLE) ? inverse : inv_q;
        d_s    = (state_q == S_IDLE) ? diff_log_n : d_q;
        k_n    = (state_q == S_IDLE) ? 0 : int'(pass_idx) + 1;
        l_n    = LOG_N - int'(d_s);
        p_n    = (l_n + LOG_E - 1) / LOG_E;
        j_n    = inv_s ? (p_n - 1 - k_n) : k_n;
        base_n = j_n * LOG_E;
        lv_n   = l_n - base_n;
        if (lv_n > LOG_E) lv_n = LOG_E;
        if (lv_n < 1) lv_n = 1;
        last_n = PW'(p_n - 1);
        base_c = PW'(base_n);
        lv_c   = EW'(lv_n);
        mask_c = LOG_E'((1 << (LOG_E - lv_n)) - 1);
    end

    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        rd_en     = (state_q == S_RUN) && !stall;
        wr_en     = vsr[PIPE_LAT-1];
        last_rd   = rd_en && (load_idx == chunks_m1);
        last_wr   = wr_en && (store_idx == chunks_m1);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (diff_log_n > ADDR_MAX) begin
                        start_bad = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (last_rd) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_wr) begin
                    state_d = (pass_idx == last_q) ? S_DONE : S_TURN;
                end
            end
            S_TURN: state_d = S_RUN;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= S_IDLE;
            cfg_err         <= 1'b0;
            vsr             <= '0;
            load_idx        <= '0;
            store_idx       <= '0;
            inv_q           <= 1'b0;
            d_q             <= '0;
            last_q          <= '0;
            pass_idx        <= '0;
            pass_base_level <= '0;
            pass_levels     <= '0;
            skip_mask       <= '0;
        end else begin
            state_q <= state_d;
            cfg_err <= start_bad;
            vsr     <= {vsr[PIPE_LAT-2:0], rd_en};
            if (rd_en) load_idx <= last_rd ? '0 : load_idx + ADDR_W'(1);
            if (wr_en) store_idx <= last_wr ? '0 : store_idx + ADDR_W'(1);
            if (start_ok) begin
                inv_q           <= inverse;
                d_q             <= diff_log_n;
                last_q          <= last_n;
                pass_idx        <= '0;
                pass_base_level <= base_c;
                pass_levels     <= lv_c;
                skip_mask       <= mask_c;
            end else if (state_d == S_TURN) begin
                pass_idx        <= pass_idx + PW'(1);
                pass_base_level <= base_c;
                pass_levels     <= lv_c;
                skip_mask       <= mask_c;
            end else if (state_d == S_IDLE) begin
                pass_idx        <= '0;
                pass_base_level <= '0;
                pass_levels     <= '0;
                skip_mask       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ntt_pass_sequencer.sv
// Bench for ntt_pass_sequencer: table of transform configurations checked
// against a write scoreboard, plus reset, cfg_err and restart sequences.
module tb_ntt_pass_sequencer;

    localparam int LOG_N = 7;
    localparam int LOG_E = 3;
    localparam int PL    = 5;
    localparam int AW    = 4;
    localparam int DW    = 3;
    localparam int PW    = 3;
    localparam int EW    = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          inverse;
    logic [DW-1:0] diff_log_n;
    logic          stall;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] pass_idx;
    logic [PW-1:0] pass_base_level;
    logic [EW-1:0] pass_levels;
    logic [LOG_E-1:0] skip_mask;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        int cyc;
        int addr;
    } wr_t;

    typedef struct packed {
        bit            inv;
        int            d;
        int            lo;
        int            hi;
        int            dup;
        int            np;
        bit [2:0][7:0] base;
        bit [2:0][7:0] lv;
        bit [2:0][7:0] mk;
        int            done_c;
    } vec_t;

    wr_t  sbq[$];
    vec_t tab[7];
    int   rev4[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    ntt_pass_sequencer #(
        .LOG_N(LOG_N),
        .LOG_E(LOG_E),
        .PIPE_LAT(PL)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .inverse(inverse),
        .diff_log_n(diff_log_n),
        .stall(stall),
        .busy(busy),
        .done(done),
        .cfg_err(cfg_err),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .pass_idx(pass_idx),
        .pass_base_level(pass_base_level),
        .pass_levels(pass_levels),
        .skip_mask(skip_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic [31:0] all_outs();
        return {8'd0, busy, done, cfg_err, rd_en, wr_en, rd_addr, wr_addr,
                pass_idx, pass_base_level, pass_levels, skip_mask};
    endfunction

    function automatic vec_t mk(bit inv, int d, int lo, int hi, int dup,
                                int np, int b0, int l0, int m0, int b1,
                                int l1, int m1, int b2, int l2, int m2,
                                int done_c);
        vec_t v;
        v.inv = inv;   v.d = d;     v.lo = lo;  v.hi = hi;
        v.dup = dup;   v.np = np;   v.done_c = done_c;
        v.base[0] = 8'(b0); v.lv[0] = 8'(l0); v.mk[0] = 8'(m0);
        v.base[1] = 8'(b1); v.lv[1] = 8'(l1); v.mk[1] = 8'(m1);
        v.base[2] = 8'(b2); v.lv[2] = 8'(l2); v.mk[2] = 8'(m2);
        return v;
    endfunction

    task automatic run(input vec_t v);
        int  rd_cnt;
        int  wr_cnt;
        int  ch;
        int  p;
        bit  fin;
        bit  busy_ok;
        wr_t w;
        rd_cnt  = 0;
        wr_cnt  = 0;
        fin     = 1'b0;
        busy_ok = 1'b1;
        ch      = 16 >> v.d;
        sbq.delete();
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            start      = (c == 0) || (c == v.dup);
            inverse    = (c == 0) ? v.inv : ~v.inv;
            diff_log_n = (c == 0) ? DW'(v.d) : 3'd2;
            stall      = (c >= v.lo) && (c <= v.hi);
            #1;
            if (c >= 1 && !done && !busy) busy_ok = 1'b0;
            if (stall) chk("rd_en_in_stall", {31'd0, rd_en}, 0);
            if (rd_en) begin
                if (rd_cnt < v.np * ch) begin
                    chk("rd_addr", {28'd0, rd_addr}, rev4[rd_cnt % ch] >> v.d);
                    if (rd_cnt % ch == 0) begin
                        p = rd_cnt / ch;
                        chk("pass_idx", {29'd0, pass_idx}, p);
                        chk("pass_base", {29'd0, pass_base_level}, {24'd0, v.base[p]});
                        chk("pass_levels", {30'd0, pass_levels}, {24'd0, v.lv[p]});
                        chk("skip_mask", {29'd0, skip_mask}, {24'd0, v.mk[p]});
                    end
                end else begin
                    fail("rd_extra", rd_cnt + 1, v.np * ch);
                end
                w.cyc  = c + PL;
                w.addr = rev4[rd_cnt % ch] >> v.d;
                sbq.push_back(w);
                rd_cnt++;
            end
            if (wr_en) begin
                if (sbq.size() == 0) begin
                    fail("wr_unexpected", c, -1);
                end else begin
                    w = sbq.pop_front();
                    chk("wr_cycle", c, w.cyc);
                    chk("wr_addr", {28'd0, wr_addr}, w.addr);
                    if (wr_cnt / ch < v.np)
                        chk("wr_pass_base", {29'd0, pass_base_level},
                            {24'd0, v.base[wr_cnt / ch]});
                end
                wr_cnt++;
            end
            if (done) begin
                fin = 1'b1;
                chk("done_cycle", c, v.done_c);
                chk("busy_at_done", {31'd0, busy}, 0);
                chk("reads_total", rd_cnt, v.np * ch);
                chk("writes_total", wr_cnt, v.np * ch);
                chk("sb_empty", sbq.size(), 0);
            end
        end
        if (!fin) fail("done_timeout", rd_cnt, v.np * ch);
        chk("busy_held", {31'd0, busy_ok}, 1);
        @(negedge clk);
        start = 1'b0;
        stall = 1'b0;
        #1;
        chk("idle_outputs", all_outs(), 0);
    endtask

    initial begin
        bit bad;
        tab[0] = mk(0, 1, -1, -2, 5, 2, 0, 3, 0, 3, 3, 0, 0, 0, 0, 28);
        tab[1] = mk(0, 0, -1, -2, -1, 3, 0, 3, 0, 3, 3, 0, 6, 1, 3, 66);
        tab[2] = mk(1, 0, -1, -2, -1, 3, 6, 1, 3, 3, 3, 0, 0, 3, 0, 66);
        tab[3] = mk(0, 4, -1, -2, -1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 7);
        tab[4] = mk(0, 1, 3, 5, -1, 2, 0, 3, 0, 3, 3, 0, 0, 0, 0, 31);
        tab[5] = mk(1, 2, -1, -2, -1, 2, 3, 2, 1, 0, 3, 0, 0, 0, 0, 20);
        tab[6] = mk(1, 3, -1, -2, -1, 2, 3, 1, 3, 0, 3, 0, 0, 0, 0, 16);

        rstn       = 1'b0;
        start      = 1'b0;
        inverse    = 1'b0;
        diff_log_n = '0;
        stall      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", all_outs(), 0);
        @(negedge clk);
        rstn = 1'b1;

        // rejected configuration
        @(negedge clk);
        start      = 1'b1;
        diff_log_n = 3'd5;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("cfg_err_pulse", {31'd0, cfg_err}, 1);
        chk("cfg_err_busy", {31'd0, busy}, 0);
        chk("cfg_err_rd", {31'd0, rd_en}, 0);
        @(negedge clk);
        #1;
        chk("cfg_err_clear", {30'd0, cfg_err, busy}, 0);

        // reset in the middle of a transform
        @(negedge clk);
        start      = 1'b1;
        inverse    = 1'b0;
        diff_log_n = 3'd1;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        chk("mid_busy", {31'd0, busy}, 1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_mid_outputs", all_outs(), 0);
        @(negedge clk);
        rstn = 1'b1;
        bad  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (wr_en || busy) bad = 1'b1;
        end
        chk("no_wr_after_rst", {31'd0, bad}, 0);

        for (int i = 0; i < 7; i++) begin
            run(tab[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
